fazyrv_shftreg_seq: RTL and testbench



---
 rtl/fazyrv_shftreg_seq.sv | 138 +++++++++++++
 tb/tb_fazyrv_shftreg_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fazyrv_shftreg_seq.sv
`default_nettype none
// ============================================================================
// Module      : fazyrv_shftreg_seq
// Description : Sequencer for a chunk-serial register file of 32-bit shift
//               registers; optional stall input via FAZYRV_SHFTREG_SEQ_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fazyrv_shftreg_seq #(
    parameter int BWIDTH = 1,
    parameter int NREGS  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_in,
    input  logic                         start_i,
`ifdef FAZYRV_SHFTREG_SEQ_STALL_EN
    input  logic                         stall_i,
`endif
    output logic                         ready_o,
    input  logic [4:0]                   rs1_i,
    input  logic [4:0]                   rs2_i,
    input  logic [4:0]                   rd_i,
    input  logic                         we_i,
    output logic [BWIDTH-1:0]            rs1_dat_o,
    output logic [BWIDTH-1:0]            rs2_dat_o,
    input  logic [BWIDTH-1:0]            rd_dat_i,
    output logic [$clog2(32/BWIDTH)-1:0] cnt_o,
    output logic                         done_o,
    output logic [NREGS-1:0]             shft_o,
    input  logic [NREGS*BWIDTH-1:0]      regs_dat_i,
    output logic [NREGS*BWIDTH-1:0]      regs_dat_o
);

    localparam int CHUNKS = 32 / BWIDTH;
    localparam int CW     = $clog2(CHUNKS);
    localparam logic [CW-1:0] c_last = CW'(CHUNKS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_we;

    logic            w_stall;
    logic            w_run;
    logic            w_adv;
    logic            w_last;
    logic [BWIDTH-1:0] w_rs1_dat;
    logic [BWIDTH-1:0] w_rs2_dat;

`ifdef FAZYRV_SHFTREG_SEQ_STALL_EN
    assign w_stall = stall_i;
`else
    assign w_stall = 1'b0;
`endif

    assign w_run  = (r_state == S_RUN);
    assign w_adv  = w_run && !w_stall;
    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_rs1   <= rs1_i;
                        r_rs2   <= rs2_i;
                        r_rd    <= rd_i;
                        r_we    <= we_i;
                    end
                end
                S_RUN: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // x0 is never selected: the scan starts at register 1, so it reads as zero.
    always_comb begin
        w_rs1_dat = '0;
        w_rs2_dat = '0;
        if (w_run) begin
            for (int k = 1; k < NREGS; k++) begin
                if (r_rs1 == 5'(k)) w_rs1_dat = regs_dat_i[k*BWIDTH +: BWIDTH];
                if (r_rs2 == 5'(k)) w_rs2_dat = regs_dat_i[k*BWIDTH +: BWIDTH];
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < NREGS; k++) begin : g_reg
            localparam logic [4:0] c_idx = 5'(k);

            if (k == 0) begin : g_x0
                assign shft_o[k] = 1'b0;
            end else begin : g_xn
                assign shft_o[k] = w_adv && ((r_rs1 == c_idx) || (r_rs2 == c_idx) ||
                                             (r_we && (r_rd == c_idx)));
            end

            // Unwritten registers take their own output chunk back, i.e. rotate.
            assign regs_dat_o[k*BWIDTH +: BWIDTH] = (r_we && (r_rd == c_idx)) ?
                                                    rd_dat_i : regs_dat_i[k*BWIDTH +: BWIDTH];
        end
    endgenerate

    assign ready_o   = (r_state == S_IDLE);
    assign done_o    = w_adv && w_last;
    assign cnt_o     = r_cnt;
    assign rs1_dat_o = w_rs1_dat;
    assign rs2_dat_o = w_rs2_dat;

endmodule
`default_nettype wire

// File: tb/tb_fazyrv_shftreg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fazyrv_shftreg_seq
// Description : Self-checking bench: shift-register file environment around a
//               BWIDTH=4 and a BWIDTH=1 sequencer, scoreboard of chunk outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fazyrv_shftreg_seq;

    localparam int CH4 = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic init  = 1'b1;

    logic         start4 = 1'b0, we4 = 1'b0, stall4 = 1'b0;
    logic [4:0]   rs1_4 = '0, rs2_4 = '0, rd_4 = '0;
    logic [3:0]   rd_dat4 = '0;
    logic         ready4, done4;
    logic [3:0]   rs1d4, rs2d4;
    logic [2:0]   cnt4;
    logic [31:0]  shft4;
    logic [127:0] rdi4, rdo4;

    logic         start1 = 1'b0;
    logic         ready1, done1, rs1d1, rs2d1;
    logic [4:0]   cnt1;
    logic [31:0]  shft1, rdi1, rdo1;

    logic         ld4 = 1'b0;
    logic [4:0]   ld_idx = '0;
    logic [31:0]  ld_val = '0;
    logic [31:0]  rf4 [32];
    logic [31:0]  rf1 [32];
    logic [31:0]  exp4 [32];

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [2:0]  cnt;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        done;
        logic [31:0] shft;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] wdata;
        int          stall_at, stall_len;
        logic        hold;
        logic [4:0]  chk_reg;
        logic [31:0] chk_val;
    } op_t;

    always #5 clk = ~clk;

    fazyrv_shftreg_seq #(.BWIDTH(4), .NREGS(32)) u_dut4 (
        .clk_i(clk), .rst_in(rst_n), .start_i(start4),
`ifdef FAZYRV_SHFTREG_SEQ_STALL_EN
        .stall_i(stall4),
`endif
        .ready_o(ready4), .rs1_i(rs1_4), .rs2_i(rs2_4), .rd_i(rd_4), .we_i(we4),
        .rs1_dat_o(rs1d4), .rs2_dat_o(rs2d4), .rd_dat_i(rd_dat4), .cnt_o(cnt4),
        .done_o(done4), .shft_o(shft4), .regs_dat_i(rdi4), .regs_dat_o(rdo4)
    );

    fazyrv_shftreg_seq #(.BWIDTH(1), .NREGS(32)) u_dut1 (
        .clk_i(clk), .rst_in(rst_n), .start_i(start1),
`ifdef FAZYRV_SHFTREG_SEQ_STALL_EN
        .stall_i(1'b0),
`endif
        .ready_o(ready1), .rs1_i(5'd5), .rs2_i(5'd6), .rd_i(5'd0), .we_i(1'b0),
        .rs1_dat_o(rs1d1), .rs2_dat_o(rs2d1), .rd_dat_i(1'b0), .cnt_o(cnt1),
        .done_o(done1), .shft_o(shft1), .regs_dat_i(rdi1), .regs_dat_o(rdo1)
    );

    function automatic logic [31:0] seed(input int k);
        logic [31:0] v;
        v = 32'h9E3779B9;
        case (k)
            0:       return 32'h0;
            3:       return 32'hA5A5A5A5;
            5:       return 32'hDEADBEEF;
            6:       return 32'h12345678;
            default: return v * 32'(k + 1);
        endcase
    endfunction

    // Register file environment: per-register shift registers, LSB chunk out first.
    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 32; k++) begin
                rf4[k] <= seed(k);
                rf1[k] <= seed(k);
            end
        end else begin
            if (ld4) rf4[ld_idx] <= ld_val;
            for (int k = 0; k < 32; k++) begin
                if (shft4[k]) rf4[k] <= {rdo4[k*4 +: 4], rf4[k][31:4]};
                if (shft1[k]) rf1[k] <= {rdo1[k], rf1[k][31:1]};
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_rf
            assign rdi4[g*4 +: 4] = rf4[g][3:0];
            assign rdi1[g]        = rf1[g][0];
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && !ready4) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("cnt", cnt4, e.cnt);
                chk("rs1_dat", rs1d4, e.r1);
                chk("rs2_dat", rs2d4, e.r2);
                chk("done", done4, e.done);
                chk("shft", shft4, e.shft);
            end
        end
    end

    function automatic op_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we,
                               logic [31:0] wdata, logic [4:0] chk_reg, logic [31:0] chk_val);
        op_t o;
        o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.we = we; o.wdata = wdata;
        o.stall_at = -1; o.stall_len = 0; o.hold = 1'b0;
        o.chk_reg = chk_reg; o.chk_val = chk_val;
        return o;
    endfunction

    task automatic load4(input logic [4:0] idx, input logic [31:0] v);
        ld4 = 1'b1; ld_idx = idx; ld_val = v;
        @(posedge clk); #1;
        ld4 = 1'b0;
        exp4[idx] = v;
    endtask

    task automatic issue4(input op_t op);
        int          budget;
        logic [31:0] m;
        sb_t         e;
        budget = 0;
        while (!ready4 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("ready_before_issue", ready4, 1'b1);
        m = '0;
        if (op.rs1 != 0) m[op.rs1] = 1'b1;
        if (op.rs2 != 0) m[op.rs2] = 1'b1;
        if (op.we && op.rd != 0) m[op.rd] = 1'b1;
        for (int c = 0; c < CH4; c++) begin
            int n;
            n = (c == op.stall_at) ? op.stall_len : 0;
            for (int s = 0; s <= n; s++) begin
                e.cnt  = 3'(c);
                e.r1   = (op.rs1 == 0) ? 4'h0 : exp4[op.rs1][c*4 +: 4];
                e.r2   = (op.rs2 == 0) ? 4'h0 : exp4[op.rs2][c*4 +: 4];
                e.done = (s == n) && (c == CH4 - 1);
                e.shft = (s == n) ? m : 32'h0;
                sbq.push_back(e);
            end
        end
        start4 = 1'b1; rs1_4 = op.rs1; rs2_4 = op.rs2; rd_4 = op.rd; we4 = op.we;
        @(posedge clk); #1;
        start4 = op.hold;
        chk("busy_after_accept", ready4, 1'b0);
        for (int c = 0; c < CH4; c++) begin
            int n;
            n = (c == op.stall_at) ? op.stall_len : 0;
            for (int s = 0; s <= n; s++) begin
                rd_dat4 = op.wdata[c*4 +: 4];
                stall4  = (s < n);
                if (op.hold) chk("ready_low_in_run", ready4, 1'b0);
                @(posedge clk); #1;
            end
        end
        stall4 = 1'b0;
        chk("sb_drain", sbq.size(), 0);
        chk("ready_after_done", ready4, 1'b1);
        if (op.we && op.rd != 0) exp4[op.rd] = op.wdata;
        chk("reg_after_op", rf4[op.chk_reg], op.chk_val);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t         tbl[6];
        op_t         o;
        logic [31:0] a, b;

        for (int k = 0; k < 32; k++) exp4[k] = seed(k);
        tbl[0] = mk(5'd3,  5'd0,  5'd3,  1'b1, 32'h0F0F0F0F, 5'd3,  32'h0F0F0F0F);
        tbl[1] = mk(5'd0,  5'd0,  5'd0,  1'b1, 32'hFFFFFFFF, 5'd0,  32'h0);
        tbl[2] = mk(5'd9,  5'd9,  5'd10, 1'b1, 32'hCAFEF00D, 5'd10, 32'hCAFEF00D);
        tbl[3] = mk(5'd11, 5'd12, 5'd12, 1'b1, 32'h13572468, 5'd12, 32'h13572468);
        tbl[4] = mk(5'd31, 5'd1,  5'd2,  1'b0, 32'hFFFFFFFF, 5'd2,  seed(2));
        tbl[5] = mk(5'd3,  5'd10, 5'd31, 1'b1, 32'h89ABCDEF, 5'd31, 32'h89ABCDEF);

        @(posedge clk); #1;
        init = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", ready4, 1'b1);
        chk("rst_done", done4, 1'b0);
        chk("rst_cnt", cnt4, 0);
        chk("rst_shft", shft4, 0);
        chk("rst_rs1_dat", rs1d4, 0);
        chk("rst_rs2_dat", rs2d4, 0);
        chk("rst_passthru", rdo4 === rdi4, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // BWIDTH=1 read/rotate of x5 and x6
        a = 32'hDEADBEEF;
        b = 32'h12345678;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk("bw1_cnt", cnt1, c);
            chk("bw1_rs1", rs1d1, a[c]);
            chk("bw1_rs2", rs2d1, b[c]);
            chk("bw1_done", done1, c == 31);
            @(posedge clk); #1;
        end
        chk("bw1_ready", ready1, 1'b1);
        chk("bw1_x5", rf1[5], 32'hDEADBEEF);
        chk("bw1_x6", rf1[6], 32'h12345678);

        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) issue4(tbl[i]);

        // start held through RUN; second op accepted in the first idle cycle
        o = mk(5'd7, 5'd8, 5'd7, 1'b1, 32'h11223344, 5'd7, 32'h11223344);
        o.hold = 1'b1;
        issue4(o);
        issue4(mk(5'd7, 5'd8, 5'd0, 1'b0, 32'h0, 5'd8, seed(8)));

        // reset in the middle of an operation
        mon_en = 1'b0;
        start4 = 1'b1; rs1_4 = 5'd13; rs2_4 = 5'd14; rd_4 = 5'd15; we4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("cnt_before_rst", cnt4, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", ready4, 1'b1);
        chk("midrst_shft", shft4, 0);
        chk("midrst_cnt", cnt4, 0);
        chk("midrst_passthru", rdo4 === rdi4, 1'b1);
        rst_n = 1'b1;
        load4(5'd13, seed(13));
        load4(5'd14, seed(14));
        load4(5'd15, seed(15));
        mon_en = 1'b1;
        issue4(mk(5'd13, 5'd14, 5'd15, 1'b1, 32'hA1B2C3D4, 5'd15, 32'hA1B2C3D4));

`ifdef FAZYRV_SHFTREG_SEQ_STALL_EN
        o = mk(5'd20, 5'd21, 5'd21, 1'b1, 32'h5EEDF00D, 5'd21, 32'h5EEDF00D);
        o.stall_at = 1;
        o.stall_len = 2;
        issue4(o);
`endif

        for (int k = 0; k < 32; k++) chk("final_reg", rf4[k], exp4[k]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
